// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// The loader sits on the slave side: it consumes bytes and drives the memory port.
interface instr_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit words, writes them
// to instruction memory, then releases the core from reset.
module instr_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned RST_CYC = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  instr_loader_if.slave  bus,
  output logic           core_rst_o,
  output logic           core_en_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);

  localparam logic [16:0] Cap    = 17'(2 ** ADDR_W);
  localparam logic [4:0]  RunCap = 5'(RST_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StRun, StErr} state_e;

  state_e            state_q, state_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              core_en_q, core_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              take;
  logic [15:0]       n_len;

  assign take  = bus.byte_valid & ready_q;
  assign n_len = {bus.byte_data, lo_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lo_q       <= '0;
      len_q      <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      core_en_q  <= core_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (start_i) begin
          state_d = StLenLo;
          widx_d  = '0;
          bidx_d  = '0;
        end
      end
      StLenLo: begin
        if (take) begin
          lo_d    = bus.byte_data;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (take) begin
          len_d = n_len[ADDR_W:0];
          if (n_len == 16'd0)             state_d = StRun;
          else if ({1'b0, n_len} > Cap)   state_d = StErr;
          else                            state_d = StData;
        end
      end
      StData: begin
        // All words counted means this is the last strobe cycle.
        if (widx_q == len_q) begin
          state_d = StRun;
        end else if (take) begin
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = {bus.byte_data, word_q};
            widx_d  = widx_q + 1'b1;
            bidx_d  = 2'd0;
          end else begin
            word_d[{bidx_q, 3'b000} +: 8] = bus.byte_data;
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Counts cycles spent in RUN, saturating once the core is released.
    if (state_d != StRun)      cnt_d = '0;
    else if (state_q != StRun) cnt_d = 5'd1;
    else if (cnt_q == RunCap)  cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 5'd1;
  end

  always_comb begin
    ready_d    = (state_d == StLenLo) || (state_d == StLenHi) ||
                 ((state_d == StData) && (widx_d != len_d));
    busy_d     = (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData);
    done_d     = (state_d == StRun);
    err_d      = (state_d == StErr);
    core_en_d  = done_d && (cnt_d == RunCap);
    core_rst_d = !core_en_d;
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst_o     = core_rst_q;
  assign core_en_o      = core_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: loads, stalls, zero length, overflow, reload, reset.
module tb_instr_loader;
  localparam int unsigned AW = 2;
  localparam int unsigned RC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_rst, core_en, busy, done, err;

  instr_loader_if #(.ADDR_W(AW)) bus ();

  instr_loader #(.ADDR_W(AW), .RST_CYC(RC)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .bus        (bus),
    .core_rst_o (core_rst),
    .core_en_o  (core_en),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  stim[$];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wa_q.push_back(32'(bus.imem_addr));
      wd_q.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    do begin @(negedge clk); n++; end while (!bus.byte_ready && n < 40);
    if (!bus.byte_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_stim(input bit gaps);
    for (int i = 0; i < stim.size(); i++) send(stim[i], gaps ? ((i % 2) ? 3 : 1) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    check("done_reached", 32'(done), 32'd1);
  endtask

  // Entered at the first RUN cycle's negedge.
  task automatic check_release(input string tag);
    for (int i = 0; i < RC; i++) begin
      check({tag, "_rst_hold"}, 32'(core_rst), 32'd1);
      check({tag, "_en_hold"}, 32'(core_en), 32'd0);
      @(negedge clk);
    end
    check({tag, "_rst_rel"}, 32'(core_rst), 32'd0);
    check({tag, "_en_rel"}, 32'(core_en), 32'd1);
    check({tag, "_ready_run"}, 32'(bus.byte_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word load, valid every cycle
    pulse_start();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_ready", 32'(bus.byte_ready), 32'd1);
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_stim(1'b0);
    wait_done();
    check("t2_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("t2_a0", wa_q[0], 32'd0);
      check("t2_d0", wd_q[0], 32'h00A00513);
      check("t2_a1", wa_q[1], 32'd1);
      check("t2_d1", wd_q[1], 32'h00100593);
    end
    check_release("t2");

    // Reload from RUN with a one-word stream
    pulse_start();
    check("t6_en", 32'(core_en), 32'd0);
    check("t6_rst", 32'(core_rst), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    clear_log();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim(1'b0);
    wait_done();
    check("t6_nwr", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check("t6_a0", wa_q[0], 32'd0);
      check("t6_d0", wd_q[0], 32'hDEADBEEF);
    end
    check_release("t6");

    // Same two-word stream with gaps in byte_valid
    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_stim(1'b1);
    wait_done();
    check_release("t3");
    repeat (4) @(negedge clk);
    check("t3_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("t3_a0", wa_q[0], 32'd0);
      check("t3_d0", wd_q[0], 32'h00A00513);
      check("t3_a1", wa_q[1], 32'd1);
      check("t3_d1", wd_q[1], 32'h00100593);
    end
    @(posedge clk); #1;

    // Zero length
    clear_log();
    pulse_start();
    stim = '{8'h00, 8'h00};
    send_stim(1'b0);
    wait_done();
    check_release("t4");
    check("t4_nwr", 32'(wa_q.size()), 32'd0);

    // Overflow: 5 words into a 4-word memory
    clear_log();
    pulse_start();
    stim = '{8'h05, 8'h00};
    send_stim(1'b0);
    @(negedge clk);
    check("t5_err", 32'(err), 32'd1);
    check("t5_ready", 32'(bus.byte_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_core_rst", 32'(core_rst), 32'd1);
    check("t5_core_en", 32'(core_en), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_err_hold", 32'(err), 32'd1);
    check("t5_nwr", 32'(wa_q.size()), 32'd0);
    @(posedge clk); #1;
    pulse_start();
    check("t5_err_clr", 32'(err), 32'd0);
    check("t5_busy_set", 32'(busy), 32'd1);

    // Full-capacity load: 4 words, addresses 0..3
    stim = '{8'h04, 8'h00};
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++) stim.push_back(8'((w << 4) | k));
    send_stim(1'b0);
    wait_done();
    check("cap_nwr", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      check("cap_a3", wa_q[3], 32'd3);
      check("cap_d0", wd_q[0], 32'h03020100);
      check("cap_d3", wd_q[3], 32'h33323130);
    end
    check_release("cap");

    // Reset asserted during a write strobe
    clear_log();
    pulse_start();
    stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stim(1'b0);
    check("t1_we_pre", 32'(bus.imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_we", 32'(bus.imem_we), 32'd0);
    check("t1_core_rst", 32'(core_rst), 32'd1);
    check("t1_core_en", 32'(core_en), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("t1_idle_ready", 32'(bus.byte_ready), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_done", 32'(done), 32'd0);
    check("t1_nwr", 32'(wa_q.size()), 32'd0);

    // Reset mid-word discards partial bytes
    pulse_start();
    stim = '{8'h01, 8'h00, 8'h99, 8'h98};
    send_stim(1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    pulse_start();
    stim = '{8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    send_stim(1'b0);
    wait_done();
    check("pd_nwr", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) check("pd_d0", wd_q[0], 32'h88776655);
    check_release("pd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
